// File: rtl/bin_gray_pkg.sv
// Shared definitions for binary/Gray encoders.
//   MAX_SIZE  widest supported code word
//   bin2gray  reflected Gray encode of the low 'width' bits of value
//   gray2bin  reflected Gray decode of the low 'width' bits of value
// Both helpers work on a MAX_SIZE-wide container so any width up to
// MAX_SIZE can share one function; bits above 'width' return as zero.
package bin_gray_pkg;

    localparam int unsigned MAX_SIZE = 32;

    // Mask built by shifting all-ones right, so width == MAX_SIZE never
    // needs a 1 << MAX_SIZE term.
    function automatic logic [MAX_SIZE-1:0] width_mask(input int unsigned width);
        return {MAX_SIZE{1'b1}} >> (MAX_SIZE - width);
    endfunction

    function automatic logic [MAX_SIZE-1:0] bin2gray(input logic [MAX_SIZE-1:0] value,
                                                     input int unsigned width);
        logic [MAX_SIZE-1:0] v;
        v = value & width_mask(width);
        return v ^ (v >> 1);
    endfunction

    function automatic logic [MAX_SIZE-1:0] gray2bin(input logic [MAX_SIZE-1:0] value,
                                                     input int unsigned width);
        logic [MAX_SIZE-1:0] v;
        logic [MAX_SIZE-1:0] acc;
        v   = value & width_mask(width);
        acc = '0;
        // Bit j of the result is the XOR of all Gray bits at or above j.
        for (int i = 0; i < int'(MAX_SIZE); i++) begin
            acc = acc ^ (v >> i);
        end
        return acc;
    endfunction

endpackage

// File: rtl/binary_to_gray_if.sv
// Signal bundle for binary_to_gray.
//   bin, in_valid        : value to encode and its qualifier (master -> slave)
//   gray, out_valid      : registered Gray result and its qualifier (slave -> master)
//   bin_rt, rt_err       : round-trip decode of gray and self-check flag (slave -> master)
interface binary_to_gray_if #(
    parameter int unsigned SIZE = 8
);

    logic [SIZE-1:0] bin;
    logic            in_valid;
    logic [SIZE-1:0] gray;
    logic            out_valid;
    logic [SIZE-1:0] bin_rt;
    logic            rt_err;

    modport master (
        output bin,
        output in_valid,
        input  gray,
        input  out_valid,
        input  bin_rt,
        input  rt_err
    );

    modport slave (
        input  bin,
        input  in_valid,
        output gray,
        output out_valid,
        output bin_rt,
        output rt_err
    );

endinterface

// File: rtl/gray_to_binary.sv
// Combinational reflected-Gray to binary decoder.
//   gray : Gray-coded input
//   bin  : decoded binary, bin[j] = XOR of gray[SIZE-1:j]
module gray_to_binary #(
    parameter int unsigned SIZE = 8
) (
    input  logic [SIZE-1:0] gray,
    output logic [SIZE-1:0] bin
);

    logic [SIZE-1:0] acc;

    // Prefix XOR from the MSB down, written as an XOR of right shifts so the
    // vector never feeds back into itself bit by bit.
    always_comb begin
        acc = '0;
        for (int i = 0; i < int'(SIZE); i++) begin
            acc = acc ^ (gray >> i);
        end
    end

    assign bin = acc;

endmodule

// File: rtl/binary_to_gray.sv
// Registered binary to reflected-Gray converter with valid qualifier and an
// in-system round-trip self-check.
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset
//   bus   : slave side of binary_to_gray_if
//           bin/in_valid in; gray/out_valid/bin_rt/rt_err out
// One cycle of latency, no backpressure. rt_err flags any disagreement
// between the decoded Gray register and the stored copy of the input.
module binary_to_gray
    import bin_gray_pkg::*;
#(
    parameter int unsigned SIZE = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    binary_to_gray_if.slave        bus
);

    if (SIZE < 1 || SIZE > MAX_SIZE) begin : g_size_check
        $error("binary_to_gray: SIZE must be in 1..%0d", MAX_SIZE);
    end

    logic [SIZE-1:0] gray_q, gray_d;
    logic [SIZE-1:0] bin_q, bin_d;
    logic            valid_q, valid_d;
    logic [SIZE-1:0] bin_rt;

    // Capture only on in_valid so an undriven bin never reaches the registers.
    always_comb begin
        gray_d  = gray_q;
        bin_d   = bin_q;
        valid_d = 1'b0;
        if (bus.in_valid) begin
            gray_d  = bus.bin ^ (bus.bin >> 1);
            bin_d   = bus.bin;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            gray_q  <= '0;
            bin_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            gray_q  <= gray_d;
            bin_q   <= bin_d;
            valid_q <= valid_d;
        end
    end

    gray_to_binary #(
        .SIZE (SIZE)
    ) u_decode (
        .gray (gray_q),
        .bin  (bin_rt)
    );

    assign bus.gray      = gray_q;
    assign bus.out_valid = valid_q;
    assign bus.bin_rt    = bin_rt;
    assign bus.rt_err    = valid_q & (bin_rt != bin_q);

endmodule

// File: tb/tb_binary_to_gray.sv
// Scoreboard bench for binary_to_gray at SIZE = 8, 1 and 32.
module tb_binary_to_gray;

    typedef struct {
        longint unsigned bin;
        longint unsigned gray;
        bit              sweep;
    } exp_t;

    logic clk;
    logic rst_n;

    binary_to_gray_if #(.SIZE(8))  bus8  ();
    binary_to_gray_if #(.SIZE(1))  bus1  ();
    binary_to_gray_if #(.SIZE(32)) bus32 ();

    binary_to_gray #(.SIZE(8))  u_dut8  (.clk(clk), .rst_n(rst_n), .bus(bus8));
    binary_to_gray #(.SIZE(1))  u_dut1  (.clk(clk), .rst_n(rst_n), .bus(bus1));
    binary_to_gray #(.SIZE(32)) u_dut32 (.clk(clk), .rst_n(rst_n), .bus(bus32));

    exp_t q8[$];
    exp_t q1[$];
    exp_t q32[$];

    int checks = 0;
    int errors = 0;
    logic [7:0] last_gray8 = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reflected Gray code from its counting definition: bit i toggles every
    // 2^(i+1) counts, offset by 2^i.
    function automatic longint unsigned ref_gray(input longint unsigned n, input int w);
        longint unsigned r;
        r = 0;
        for (int i = 0; i < w; i++) begin
            longint unsigned p;
            p = 64'd1 << i;
            if ((((n + p) / (p * 2)) % 2) == 1) r = r | p;
        end
        return r;
    endfunction

    task automatic check(input string name, input longint unsigned act,
                         input longint unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ---------------- monitors ----------------
    always @(negedge clk) begin
        exp_t e;
        if (bus8.out_valid) begin
            if (q8.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dut8_unexpected_output: got gray %0h, expected no output",
                         bus8.gray);
            end else begin
                e = q8.pop_front();
                check("dut8_gray", bus8.gray, e.gray);
                check("dut8_bin_rt", bus8.bin_rt, e.bin);
                check("dut8_rt_err", bus8.rt_err, 0);
                if (e.sweep)
                    check("dut8_one_bit_step", $countones(bus8.gray ^ last_gray8), 1);
            end
            last_gray8 = bus8.gray;
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (bus1.out_valid) begin
            if (q1.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dut1_unexpected_output: got gray %0h, expected no output",
                         bus1.gray);
            end else begin
                e = q1.pop_front();
                check("dut1_gray", bus1.gray, e.gray);
                check("dut1_bin_rt", bus1.bin_rt, e.bin);
                check("dut1_rt_err", bus1.rt_err, 0);
            end
        end
    end

    always @(negedge clk) begin
        exp_t e;
        if (bus32.out_valid) begin
            if (q32.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dut32_unexpected_output: got gray %0h, expected no output",
                         bus32.gray);
            end else begin
                e = q32.pop_front();
                check("dut32_gray", bus32.gray, e.gray);
                check("dut32_bin_rt", bus32.bin_rt, e.bin);
                check("dut32_rt_err", bus32.rt_err, 0);
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic send8(input logic [7:0] v, input longint unsigned g, input bit sw);
        bus8.bin      = v;
        bus8.in_valid = 1'b1;
        q8.push_back('{bin: longint'(v), gray: g, sweep: sw});
        @(posedge clk);
        #1;
    endtask

    task automatic idle8();
        bus8.in_valid = 1'b0;
        bus8.bin      = 8'($urandom);
        @(posedge clk);
        #1;
    endtask

    task automatic send1(input logic v, input longint unsigned g);
        bus1.bin      = v;
        bus1.in_valid = 1'b1;
        q1.push_back('{bin: longint'(v), gray: g, sweep: 1'b0});
        @(posedge clk);
        #1;
        bus1.in_valid = 1'b0;
    endtask

    task automatic send32(input logic [31:0] v, input longint unsigned g);
        bus32.bin      = v;
        bus32.in_valid = 1'b1;
        q32.push_back('{bin: longint'(v), gray: g, sweep: 1'b0});
        @(posedge clk);
        #1;
        bus32.in_valid = 1'b0;
    endtask

    logic [7:0]  dir_bin  [5] = '{8'h05, 8'hA5, 8'hFF, 8'h07, 8'h08};
    logic [7:0]  dir_gray [5] = '{8'h07, 8'hF7, 8'h80, 8'h04, 8'h0C};

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no end of test, expected finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n          = 1'b0;
        bus8.bin       = '0;
        bus8.in_valid  = 1'b0;
        bus1.bin       = '0;
        bus1.in_valid  = 1'b0;
        bus32.bin      = '0;
        bus32.in_valid = 1'b0;

        repeat (2) @(posedge clk);
        #1;
        check("reset_gray", bus8.gray, 0);
        check("reset_out_valid", bus8.out_valid, 0);
        check("reset_rt_err", bus8.rt_err, 0);
        rst_n = 1'b1;

        // First result after reset.
        send8(8'h00, 0, 1'b0);

        // Directed encodes from fixed constants.
        for (int i = 0; i < 5; i++) send8(dir_bin[i], longint'(dir_gray[i]), 1'b0);
        idle8();

        // Hold: gray keeps F7, out_valid drops, garbage bin ignored.
        send8(8'hA5, 64'hF7, 1'b0);
        bus8.in_valid = 1'b0;
        bus8.bin      = 8'h3C;
        @(posedge clk);
        #1;
        check("hold_gray", bus8.gray, 64'hF7);
        check("hold_out_valid", bus8.out_valid, 0);
        idle8();

        // Sequential sweep including the FF -> 00 wrap.
        for (int v = 0; v < 256; v++) send8(8'(v), ref_gray(longint'(v), 8), v != 0);
        send8(8'h00, ref_gray(0, 8), 1'b1);
        idle8();

        // Random 8-bit traffic with gaps.
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 3) != 0) begin
                logic [7:0] r;
                r = 8'($urandom);
                send8(r, ref_gray(longint'(r), 8), 1'b0);
            end else begin
                idle8();
            end
        end
        idle8();

        // Width corners.
        send1(1'b1, 1);
        send1(1'b0, 0);
        for (int i = 0; i < 4; i++) begin
            logic r1;
            r1 = 1'($urandom);
            send1(r1, ref_gray(longint'(r1), 1));
        end
        send32(32'hFFFF_FFFF, 64'h8000_0000);
        send32(32'h8000_0000, 64'hC000_0000);
        for (int i = 0; i < 40; i++) begin
            logic [31:0] r32;
            r32 = $urandom;
            send32(r32, ref_gray(longint'(r32), 32));
        end
        repeat (2) @(posedge clk);
        #1;

        // Reset in the middle of a continuous valid stream.
        for (int i = 0; i < 6; i++) begin
            logic [7:0] r;
            r = 8'($urandom);
            send8(r, ref_gray(longint'(r), 8), 1'b0);
        end
        bus8.bin      = 8'($urandom);
        bus8.in_valid = 1'b1;
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_gray", bus8.gray, 0);
        check("midrst_out_valid", bus8.out_valid, 0);
        check("midrst_rt_err", bus8.rt_err, 0);
        q8.delete();
        q1.delete();
        q32.delete();
        repeat (3) begin
            @(posedge clk);
            #1;
            bus8.bin = 8'($urandom);
        end
        check("inrst_out_valid", bus8.out_valid, 0);
        check("inrst_gray", bus8.gray, 0);
        bus8.in_valid = 1'b0;
        rst_n = 1'b1;
        repeat (4) idle8();
        check("postrst_no_output", bus8.out_valid, 0);
        send8(8'hC3, ref_gray(64'hC3, 8), 1'b0);
        repeat (3) idle8();

        check("q8_drained", q8.size(), 0);
        check("q1_drained", q1.size(), 0);
        check("q32_drained", q32.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
